// File: rtl/pattern_history_predictor.sv
// Pattern history predictor: hashes PC index with local history into a table of 2-bit
// saturating counters. Prediction is one cycle after lookup; resolved branches retrain.
module pattern_history_predictor #(
  parameter int         IDX_BITS   = 8,
  parameter int         HIST_BITS  = 8,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  input  logic        lookup_valid,
  input  logic [8:0]  lookup_index,
  input  logic [15:0] lookup_history,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [1:0]  pred_counter,
  input  logic        update_valid,
  input  logic [8:0]  update_index,
  input  logic [15:0] update_history,
  input  logic        update_taken
);

  localparam int DEPTH = 1 << IDX_BITS;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state;
  logic [IDX_BITS-1:0] ptr;
  logic [1:0]          ctr_mem [DEPTH];

  logic [IDX_BITS-1:0] lk_entry;
  logic [IDX_BITS-1:0] up_entry;
  logic [1:0]          up_cur;
  logic [1:0]          up_next;
  logic [1:0]          lk_cur;
  logic [1:0]          lk_bypassed;
  logic                run;
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_addr;
  logic [1:0]          wr_dat;
  logic                unused_bits;

  assign unused_bits = ^{lookup_index, lookup_history, update_index, update_history};

  assign lk_entry = lookup_index[IDX_BITS-1:0] ^ IDX_BITS'(lookup_history[HIST_BITS-1:0]);
  assign up_entry = update_index[IDX_BITS-1:0] ^ IDX_BITS'(update_history[HIST_BITS-1:0]);

  assign run    = (state == ST_RUN);
  assign ready  = run;
  assign up_cur = ctr_mem[up_entry];
  assign lk_cur = ctr_mem[lk_entry];

  always_comb begin
    up_next = up_cur;
    if (update_taken) begin
      if (up_cur != 2'b11) up_next = up_cur + 2'b01;
    end else begin
      if (up_cur != 2'b00) up_next = up_cur - 2'b01;
    end
  end

  // A same-entry update in the lookup cycle must be visible in the prediction.
  always_comb begin
    lk_bypassed = lk_cur;
    if (update_valid && (up_entry == lk_entry)) lk_bypassed = up_next;
  end

  // Single write port: the init sweep owns it in INIT, training owns it in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ptr;
    wr_dat  = INIT_STATE;
    if (!run) begin
      wr_en = 1'b1;
    end else if (update_valid) begin
      wr_en   = 1'b1;
      wr_addr = up_entry;
      wr_dat  = up_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ctr_mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + 1'b1;
      if (ptr == {IDX_BITS{1'b1}}) state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      pred_counter <= 2'b00;
    end else begin
      pred_valid <= run && lookup_valid;
      if (run && lookup_valid) begin
        pred_counter <= lk_bypassed;
        pred_taken   <= lk_bypassed[1];
      end
    end
  end

endmodule

// File: tb/tb_pattern_history_predictor.sv
// Bench for pattern_history_predictor: directed stimulus with a scoreboard queue of
// expected counter values, popped by a monitor on every prediction pulse.
module tb_pattern_history_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready;
  logic        lookup_valid = 1'b0;
  logic [8:0]  lookup_index = '0;
  logic [15:0] lookup_history = '0;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_counter;
  logic        update_valid = 1'b0;
  logic [8:0]  update_index = '0;
  logic [15:0] update_history = '0;
  logic        update_taken = 1'b0;

  int checks = 0;
  int errors = 0;
  int init_pulses = 0;
  logic [1:0] exp_q [$];

  pattern_history_predictor #(.IDX_BITS(8), .HIST_BITS(8), .INIT_STATE(2'b01)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_history(lookup_history),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_counter(pred_counter),
    .update_valid(update_valid), .update_index(update_index), .update_history(update_history),
    .update_taken(update_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every prediction pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pred_valid) begin
      if (!ready) init_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pred: got pred_valid=1 counter=%0d expected no prediction",
                 pred_counter);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("pred_counter", int'(pred_counter), int'(e));
        check("pred_taken", int'(pred_taken), int'(e[1]));
      end
    end
  end

  // One cycle with the given lookup/update request, inputs cleared afterwards.
  task automatic cycle(input logic lv, input logic [8:0] li, input logic [15:0] lh,
                       input logic uv, input logic [8:0] ui, input logic [15:0] uh,
                       input logic ut);
    lookup_valid = lv; lookup_index = li; lookup_history = lh;
    update_valid = uv; update_index = ui; update_history = uh; update_taken = ut;
    @(posedge clk); #1;
    lookup_valid = 1'b0; update_valid = 1'b0;
  endtask

  task automatic lookup(input logic [8:0] li, input logic [15:0] lh, input logic [1:0] exp);
    exp_q.push_back(exp);
    cycle(1'b1, li, lh, 1'b0, 9'd0, 16'd0, 1'b0);
  endtask

  task automatic update(input logic [8:0] ui, input logic [15:0] uh, input logic ut,
                        input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 9'd0, 16'd0, 1'b1, ui, uh, ut);
  endtask

  // Counts cycles from reset release to ready; optionally hammers requests meanwhile.
  task automatic release_and_wait(input string name, input logic hammer);
    int n;
    n = 0;
    reset = 1'b0;
    while (!ready && n < 1000) begin
      if (hammer) begin
        lookup_valid = 1'b1; lookup_index = 9'(n); lookup_history = 16'd0;
        update_valid = 1'b1; update_index = 9'(n); update_history = 16'd0;
        update_taken = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    lookup_valid = 1'b0; update_valid = 1'b0;
    check(name, n, 256);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(ready), 0);
    check("reset_pred_valid", int'(pred_valid), 0);
    check("reset_pred_taken", int'(pred_taken), 0);
    check("reset_pred_counter", int'(pred_counter), 0);

    // 1: sweep timing and first lookup
    release_and_wait("ready_latency", 1'b0);
    lookup(9'h0AB, 16'h0000, 2'b01);

    // 2: saturation both ways, update-then-lookup in consecutive cycles
    update(9'h010, 16'h0, 1'b1, 3); lookup(9'h010, 16'h0, 2'b11);
    update(9'h010, 16'h0, 1'b1, 2); lookup(9'h010, 16'h0, 2'b11);
    update(9'h010, 16'h0, 1'b0, 4); lookup(9'h010, 16'h0, 2'b00);
    update(9'h010, 16'h0, 1'b0, 1); lookup(9'h010, 16'h0, 2'b00);
    update(9'h010, 16'h0, 1'b1, 1); lookup(9'h010, 16'h0, 2'b01);

    // 3: hash, back-to-back lookups, ignored upper bits
    update(9'h005, 16'h0003, 1'b1, 2);
    lookup(9'h006, 16'h0000, 2'b11);
    lookup(9'h005, 16'h0000, 2'b01);
    lookup(9'h005, 16'h0103, 2'b11);
    lookup(9'h106, 16'h0000, 2'b11);

    // 4: same-entry bypass, then different entries in the same cycle
    exp_q.push_back(2'b10);
    cycle(1'b1, 9'h020, 16'h0, 1'b1, 9'h020, 16'h0, 1'b1);
    lookup(9'h020, 16'h0, 2'b10);
    exp_q.push_back(2'b01);
    cycle(1'b1, 9'h021, 16'h0, 1'b1, 9'h022, 16'h0, 1'b1);
    lookup(9'h022, 16'h0, 2'b10);
    @(posedge clk); #1;
    check("idle_pred_valid", int'(pred_valid), 0);
    check("hold_pred_counter", int'(pred_counter), 2);

    // 5: requests during INIT are ignored
    reset = 1'b1;
    @(posedge clk); #1;
    check("reinit_ready", int'(ready), 0);
    init_pulses = 0;
    release_and_wait("ready_latency_hammer", 1'b1);
    check("init_pred_pulses", init_pulses, 0);
    lookup(9'h010, 16'h0, 2'b01);
    lookup(9'h020, 16'h0, 2'b01);
    lookup(9'h006, 16'h0, 2'b01);
    lookup(9'h0FF, 16'h0, 2'b01);

    // 6: reset with a prediction in flight wipes training
    update(9'h010, 16'h0, 1'b1, 2);
    lookup(9'h010, 16'h0, 2'b11);
    lookup_valid = 1'b1; lookup_index = 9'h010; lookup_history = 16'h0;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    check("inflight_pred_valid", int'(pred_valid), 1);
    reset = 1'b1;
    #1;
    check("abort_pred_valid", int'(pred_valid), 0);
    check("abort_ready", int'(ready), 0);
    check("abort_pred_counter", int'(pred_counter), 0);
    @(posedge clk); #1;
    release_and_wait("ready_latency_after_reset", 1'b0);
    lookup(9'h010, 16'h0, 2'b01);

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
